axi_led_regs: RTL and testbench
===============================

AXI_LED_REGS -- requirements
Module: axi_led_regs

Interface
REQ-001 SHALL have parameter C_ID_W, default 12: AXI ID width.
REQ-002 SHALL have parameter C_LED_RST, default 8'h55: reset value of the LED register.
REQ-003 SHALL have port i_clk, input, 1: the single clock, which is the GP0 ACLK.
REQ-004 SHALL have port i_rst_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port i_AWVALID, input, 1: write address valid.
REQ-006 SHALL have port o_AWREADY, output, 1: write address ready.
REQ-007 SHALL have port i_AWID, input, C_ID_W: write ID.
REQ-008 SHALL have port i_AWADDR, input, 32: write byte address.
REQ-009 SHALL have port i_AWLEN, input, 4: write burst length minus 1.
REQ-010 SHALL have port i_WVALID, input, 1: write data valid.
REQ-011 SHALL have port o_WREADY, output, 1: write data ready.
REQ-012 SHALL have port i_WDATA, input, 32: write data.
REQ-013 SHALL have port i_WSTRB, input, 4: write byte strobes.
REQ-014 SHALL have port o_BVALID, output, 1: write response valid.
REQ-015 SHALL have port i_BREADY, input, 1: write response ready.
REQ-016 SHALL have port o_BID, output, C_ID_W: write response ID.
REQ-017 SHALL have port o_BRESP, output, 2: write response code.
REQ-018 SHALL have port i_ARVALID, input, 1: read address valid.
REQ-019 SHALL have port o_ARREADY, output, 1: read address ready.
REQ-020 SHALL have port i_ARID, input, C_ID_W: read ID.
REQ-021 SHALL have port i_ARADDR, input, 32: read byte address.
REQ-022 SHALL have port i_ARLEN, input, 4: read burst length minus 1.
REQ-023 SHALL have port o_RVALID, output, 1: read data valid.
REQ-024 SHALL have port i_RREADY, input, 1: read data ready.
REQ-025 SHALL have port o_RID, output, C_ID_W: read ID.
REQ-026 SHALL have port o_RDATA, output, 32: read data.
REQ-027 SHALL have port o_RRESP, output, 2: read response code.
REQ-028 SHALL have port o_RLAST, output, 1: last read beat.
REQ-029 SHALL have port o_led, output, 8: LED drive.

Function
REQ-030 SHALL decode the register map from addr[3:2]: 0 LED (RW, [7:0]); 1 BLINK mask (RW, [7:0]); 2 PRESCALE (RW, 32 bits); 3 ID (RO, 32'h4C454438). Unused bits SHALL read 0, and addr[11:4] != 0 SHALL give SLVERR (2'b10): writes dropped, read data 0, all other responses OKAY.
REQ-031 SHALL treat every burst as INCR with size 4 bytes: the beat address is the start address + 4*beat, wrapping within bits [11:0]. AxBURST, AxSIZE and WLAST are ignored, and the beat count is derived from AxLEN.
REQ-032 Write FSM SHALL follow W_IDLE -(AW handshake)-> W_DATA -(final W handshake, counted)-> W_RESP -(B handshake)-> W_IDLE.
REQ-033 In the write FSM, o_AWREADY SHALL be 1 only in W_IDLE, o_WREADY only in W_DATA, and o_BVALID only in W_RESP.
REQ-034 BID SHALL equal the latched AWID, and BRESP SHALL be SLVERR if any beat errored, otherwise OKAY.
REQ-035 Each accepted W beat SHALL update the byte lanes enabled by WSTRB on the following edge; WSTRB=0 leaves the register unchanged.
REQ-036 Read FSM SHALL follow R_IDLE -(AR handshake)-> R_DATA, with one beat per RVALID&RREADY, leaving R_DATA after the beat carrying RLAST.
REQ-037 The first RVALID SHALL occur 1 cycle after the AR handshake, and RDATA/RID/RRESP/RLAST SHALL hold stable while RVALID=1 and RREADY=0.
REQ-038 Read and write channels SHALL be independent; on a same-cycle read and write of the same register, the read returns the pre-write value.
REQ-039 Blink: a 32-bit counter SHALL increment each cycle; when it equals PRESCALE it SHALL clear and toggle phase. PRESCALE=0 SHALL hold counter and phase at 0, and a write to PRESCALE SHALL clear the counter.
REQ-040 o_led SHALL be registered and equal LED ^ (BLINK & {8{phase}}), lagging register state by 1 cycle.

Reset
REQ-041 While i_rst_n=0: both FSMs IDLE; all ready/valid outputs 0; BID/RID/RDATA/BRESP/RRESP/RLAST 0; LED=C_LED_RST; BLINK=0; PRESCALE=32'd50_000_000; counter=0; phase=0; o_led=C_LED_RST.
REQ-042 Reset asserted mid-burst SHALL abandon the transaction without issuing a response, and deassertion SHALL be synchronised to i_clk inside the block.

Structure
REQ-043 Register offsets, the ID constant, the PRESCALE reset value and the RESP codes SHALL live in the shared package pl_pkg.
REQ-044 The blink counter/phase logic SHALL be the sub-module led_blink, with inputs prescale and prescale_wr and output phase.

Verification
REQ-045 Reset then idle: o_led=8'h55, and a read of 0xC returns 32'h4C454438 OKAY with RLAST=1.
REQ-046 Write 0x0=32'hA5 with WSTRB=4'h1, BREADY held 0 for 3 cycles: BVALID held, BRESP=OKAY, BID echoed, o_led=8'hA5.
REQ-047 AWLEN=3 at 0x0 with data 1,2,3,4 -> LED=1, BLINK=2, PRESCALE=3; ID unchanged; a 4-beat read returns 1,2,3,ID with RLAST only on beat 4.
REQ-048 PRESCALE=4 and BLINK=8'h0F with LED=8'h00: o_led toggles between 8'h00 and 8'h0F every 5 cycles.
REQ-049 Read 0x10 -> RRESP=SLVERR, RDATA=0; write 0x10 -> BRESP=SLVERR and no register change.
REQ-050 Assert i_rst_n=0 during beat 2 of a 4-beat read: RVALID drops, and after release a new read completes normally.

Source files
------------

// File: rtl/pl_pkg.sv
// Shared definitions for the PL LED register block.
// Word offsets (addr[3:2]), the read-only ID constant, the PRESCALE reset
// value, AXI response codes, FSM state types and a byte-strobe merge helper.
package pl_pkg;

  localparam logic [1:0]  REG_LED      = 2'd0;
  localparam logic [1:0]  REG_BLINK    = 2'd1;
  localparam logic [1:0]  REG_PRESCALE = 2'd2;
  localparam logic [1:0]  REG_ID       = 2'd3;

  localparam logic [31:0] ID_VALUE     = 32'h4C454438;
  localparam logic [31:0] PRESCALE_RST = 32'd50_000_000;

  localparam logic [1:0]  RESP_OKAY    = 2'b00;
  localparam logic [1:0]  RESP_SLVERR  = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  // Replace the byte lanes of old selected by strb with those of data.
  function automatic logic [31:0] apply_strb(input logic [31:0] old,
                                             input logic [31:0] data,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    r = old;
    for (int unsigned i = 0; i < 4; i++) begin
      if (strb[i]) r[8*i +: 8] = data[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/led_blink.sv
// Blink phase generator.
// Ports: clk, rst_n (async active-low), prescale (terminal count),
//        prescale_wr (pulse when PRESCALE is written), phase (blink phase).
// The counter runs 0..prescale, then clears and toggles phase, so phase
// toggles every prescale+1 cycles. prescale==0 parks counter and phase at 0.
module led_blink (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] prescale,
  input  logic        prescale_wr,
  output logic        phase
);

  logic [31:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      phase <= 1'b0;
    end else if (prescale == '0) begin
      count <= '0;
      phase <= 1'b0;
    end else if (prescale_wr) begin
      count <= '0;
    end else if (count == prescale) begin
      count <= '0;
      phase <= ~phase;
    end else begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/axi_led_regs.sv
// AXI3 slave register block driving eight LEDs (GP0 port).
// Ports: i_clk/i_rst_n; AW/W/B write channels; AR/R read channels;
//        o_led (registered LED drive).
// Registers (addr[3:2]): LED, BLINK, PRESCALE, ID (RO). addr[11:4] != 0
// answers SLVERR. Bursts are INCR/4-byte with the address wrapping in [11:0].
module axi_led_regs
  import pl_pkg::*;
#(
  parameter int         C_ID_W    = 12,
  parameter logic [7:0] C_LED_RST = 8'h55
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_AWVALID,
  output logic              o_AWREADY,
  input  logic [C_ID_W-1:0] i_AWID,
  input  logic [31:0]       i_AWADDR,
  input  logic [3:0]        i_AWLEN,
  input  logic              i_WVALID,
  output logic              o_WREADY,
  input  logic [31:0]       i_WDATA,
  input  logic [3:0]        i_WSTRB,
  output logic              o_BVALID,
  input  logic              i_BREADY,
  output logic [C_ID_W-1:0] o_BID,
  output logic [1:0]        o_BRESP,
  input  logic              i_ARVALID,
  output logic              o_ARREADY,
  input  logic [C_ID_W-1:0] i_ARID,
  input  logic [31:0]       i_ARADDR,
  input  logic [3:0]        i_ARLEN,
  output logic              o_RVALID,
  input  logic              i_RREADY,
  output logic [C_ID_W-1:0] o_RID,
  output logic [31:0]       o_RDATA,
  output logic [1:0]        o_RRESP,
  output logic              o_RLAST,
  output logic [7:0]        o_led
);

  // Only the low 12 address bits take part in decoding.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_AWADDR[31:12], i_ARADDR[31:12]};

  // Reset asserts asynchronously and releases two clocks later.
  logic [1:0] rst_pipe;
  logic       rst_n;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) rst_pipe <= '0;
    else          rst_pipe <= {rst_pipe[0], 1'b1};
  end
  assign rst_n = rst_pipe[1];

  logic [7:0]  led_r;
  logic [7:0]  blink_r;
  logic [31:0] prescale_r;
  logic [31:0] rd_words [4];
  logic        phase;

  always_comb begin
    rd_words[REG_LED]      = {24'd0, led_r};
    rd_words[REG_BLINK]    = {24'd0, blink_r};
    rd_words[REG_PRESCALE] = prescale_r;
    rd_words[REG_ID]       = ID_VALUE;
  end

  // ---------------------------------------------------------------- write
  w_state_t          w_state, w_next;
  logic [C_ID_W-1:0] w_id;
  logic [11:0]       w_addr;
  logic [3:0]        w_len, w_beat;
  logic              w_err;
  logic              aw_hs, w_hs, wr_ok, prescale_wr;
  logic [31:0]       wr_merged;

  always_comb begin
    w_next    = w_state;
    o_AWREADY = 1'b0;
    o_WREADY  = 1'b0;
    o_BVALID  = 1'b0;
    case (w_state)
      W_IDLE: begin
        // Held low until the synchronised reset has released.
        o_AWREADY = rst_n;
        if (i_AWVALID && rst_n) w_next = W_DATA;
      end
      W_DATA: begin
        o_WREADY = 1'b1;
        if (i_WVALID && (w_beat == w_len)) w_next = W_RESP;
      end
      W_RESP: begin
        o_BVALID = 1'b1;
        if (i_BREADY) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  assign aw_hs       = i_AWVALID & o_AWREADY;
  assign w_hs        = i_WVALID & o_WREADY;
  assign wr_ok       = w_hs && (w_addr[11:4] == 8'd0);
  assign wr_merged   = apply_strb(rd_words[w_addr[3:2]], i_WDATA, i_WSTRB);
  assign prescale_wr = wr_ok && (w_addr[3:2] == REG_PRESCALE) && (i_WSTRB != 4'd0);
  assign o_BID       = w_id;
  assign o_BRESP     = w_err ? RESP_SLVERR : RESP_OKAY;

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state <= W_IDLE;
      w_id    <= '0;
      w_addr  <= '0;
      w_len   <= '0;
      w_beat  <= '0;
      w_err   <= 1'b0;
    end else begin
      w_state <= w_next;
      if (aw_hs) begin
        w_id   <= i_AWID;
        w_addr <= i_AWADDR[11:0];
        w_len  <= i_AWLEN;
        w_beat <= '0;
        w_err  <= 1'b0;
      end else if (w_hs) begin
        w_addr <= w_addr + 12'd4;
        w_beat <= w_beat + 4'd1;
        if (w_addr[11:4] != 8'd0) w_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      led_r      <= C_LED_RST;
      blink_r    <= '0;
      prescale_r <= PRESCALE_RST;
    end else if (wr_ok) begin
      case (w_addr[3:2])
        REG_LED:      led_r      <= wr_merged[7:0];
        REG_BLINK:    blink_r    <= wr_merged[7:0];
        REG_PRESCALE: prescale_r <= wr_merged;
        default: ;
      endcase
    end
  end

  // ----------------------------------------------------------------- read
  r_state_t          r_state, r_next;
  logic [C_ID_W-1:0] r_id;
  logic [11:0]       r_addr, r_load_addr;
  logic [3:0]        r_len, r_beat;
  logic              ar_hs, r_hs, r_load_ok;

  always_comb begin
    r_next    = r_state;
    o_ARREADY = 1'b0;
    o_RVALID  = 1'b0;
    case (r_state)
      R_IDLE: begin
        o_ARREADY = rst_n;
        if (i_ARVALID && rst_n) r_next = R_DATA;
      end
      R_DATA: begin
        o_RVALID = 1'b1;
        if (i_RREADY && o_RLAST) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  assign ar_hs       = i_ARVALID & o_ARREADY;
  assign r_hs        = o_RVALID & i_RREADY;
  // Beat data is captured into the output registers one beat ahead, so a
  // same-edge write is not yet visible to the read.
  assign r_load_addr = ar_hs ? i_ARADDR[11:0] : (r_addr + 12'd4);
  assign r_load_ok   = (r_load_addr[11:4] == 8'd0);
  assign o_RID       = r_id;

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= R_IDLE;
      r_id    <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_beat  <= '0;
      o_RDATA <= '0;
      o_RRESP <= RESP_OKAY;
      o_RLAST <= 1'b0;
    end else begin
      r_state <= r_next;
      if (ar_hs || (r_hs && !o_RLAST)) begin
        r_addr  <= r_load_addr;
        o_RDATA <= r_load_ok ? rd_words[r_load_addr[3:2]] : 32'd0;
        o_RRESP <= r_load_ok ? RESP_OKAY : RESP_SLVERR;
      end
      if (ar_hs) begin
        r_id    <= i_ARID;
        r_len   <= i_ARLEN;
        r_beat  <= '0;
        o_RLAST <= (i_ARLEN == 4'd0);
      end else if (r_hs && !o_RLAST) begin
        r_beat  <= r_beat + 4'd1;
        o_RLAST <= ((r_beat + 4'd1) == r_len);
      end
    end
  end

  // ------------------------------------------------------------------ LED
  led_blink u_blink (
    .clk         (i_clk),
    .rst_n       (rst_n),
    .prescale    (prescale_r),
    .prescale_wr (prescale_wr),
    .phase       (phase)
  );

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) o_led <= C_LED_RST;
    else        o_led <= led_r ^ (blink_r & {8{phase}});
  end

endmodule

// File: tb/tb_axi_led_regs.sv
// Directed self-checking bench for axi_led_regs.
module tb_axi_led_regs;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready, rlast;
  logic [11:0] awid, bid, arid, rid;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  awlen, wstrb, arlen;
  logic [1:0]  bresp, rresp;
  logic [7:0]  led;

  int checks   = 0;
  int failures = 0;

  logic [31:0] wbuf [4];
  logic [31:0] rbuf [4];
  logic        rlb  [4];
  logic [1:0]  rrb  [4];
  logic [11:0] ridb;
  logic [1:0]  wresp;
  logic [11:0] wid;

  always #5 clk = ~clk;

  axi_led_regs #(.C_ID_W(12), .C_LED_RST(8'h55)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_AWVALID(awvalid), .o_AWREADY(awready), .i_AWID(awid),
    .i_AWADDR(awaddr), .i_AWLEN(awlen),
    .i_WVALID(wvalid), .o_WREADY(wready), .i_WDATA(wdata), .i_WSTRB(wstrb),
    .o_BVALID(bvalid), .i_BREADY(bready), .o_BID(bid), .o_BRESP(bresp),
    .i_ARVALID(arvalid), .o_ARREADY(arready), .i_ARID(arid),
    .i_ARADDR(araddr), .i_ARLEN(arlen),
    .o_RVALID(rvalid), .i_RREADY(rready), .o_RID(rid), .o_RDATA(rdata),
    .o_RRESP(rresp), .o_RLAST(rlast), .o_led(led)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [3:0] len,
                           input logic [3:0] strb, input logic [11:0] id,
                           input int bstall);
    int n;
    @(negedge clk);
    awvalid = 1'b1; awaddr = addr; awlen = len; awid = id;
    n = 0;
    while (!awready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) check("aw_timeout", 32'd1, 32'd0);
    @(negedge clk);
    awvalid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      wvalid = 1'b1; wdata = wbuf[b]; wstrb = strb;
      n = 0;
      while (!wready && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) check("w_timeout", 32'd1, 32'd0);
      @(negedge clk);
    end
    wvalid = 1'b0;
    for (int s = 0; s < bstall; s++) begin
      check("b_held", 32'(bvalid), 32'd1);
      @(negedge clk);
    end
    n = 0;
    while (!bvalid && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) check("b_timeout", 32'd1, 32'd0);
    wresp = bresp; wid = bid;
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    check("b_drop", 32'(bvalid), 32'd0);
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [3:0] len,
                          input logic [11:0] id, input int stall);
    int n;
    logic [31:0] held;
    @(negedge clk);
    arvalid = 1'b1; araddr = addr; arlen = len; arid = id;
    n = 0;
    while (!arready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) check("ar_timeout", 32'd1, 32'd0);
    @(negedge clk);
    arvalid = 1'b0;
    check("r_latency", 32'(rvalid), 32'd1);
    for (int b = 0; b <= int'(len); b++) begin
      n = 0;
      while (!rvalid && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) check("r_timeout", 32'd1, 32'd0);
      if (b == 0 && stall > 0) begin
        held = rdata;
        for (int s = 0; s < stall; s++) begin
          @(negedge clk);
          check("r_hold", rdata, held);
        end
      end
      rbuf[b] = rdata; rlb[b] = rlast; rrb[b] = rresp; ridb = rid;
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
    end
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [7:0] prev;
    rst_n = 1'b0;
    awvalid = 0; awid = '0; awaddr = '0; awlen = '0;
    wvalid = 0; wdata = '0; wstrb = '0; bready = 0;
    arvalid = 0; arid = '0; araddr = '0; arlen = '0; rready = 0;
    repeat (3) @(negedge clk);
    check("rst_awready", 32'(awready), 32'd0);
    check("rst_arready", 32'(arready), 32'd0);
    check("rst_bvalid",  32'(bvalid),  32'd0);
    check("rst_rvalid",  32'(rvalid),  32'd0);
    check("rst_led",     32'(led),     32'h55);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_led", 32'(led), 32'h55);

    // ID read, with two stall cycles on RREADY
    axi_read(32'hC, 4'd0, 12'h123, 2);
    check("id_data", rbuf[0], 32'h4C454438);
    check("id_resp", 32'(rrb[0]), 32'd0);
    check("id_last", 32'(rlb[0]), 32'd1);
    check("id_rid",  32'(ridb), 32'h123);

    // single write, BREADY withheld for 3 cycles
    wbuf[0] = 32'hA5;
    axi_write(32'h0, 4'd0, 4'h1, 12'h3A5, 3);
    check("w1_bresp", 32'(wresp), 32'd0);
    check("w1_bid",   32'(wid),   32'h3A5);
    repeat (2) @(negedge clk);
    check("w1_led",   32'(led),   32'hA5);

    // 4-beat burst over the whole map
    wbuf[0] = 32'd1; wbuf[1] = 32'd2; wbuf[2] = 32'd3; wbuf[3] = 32'd4;
    axi_write(32'h0, 4'd3, 4'hF, 12'h007, 0);
    check("wb_bresp", 32'(wresp), 32'd0);
    check("wb_bid",   32'(wid),   32'h007);
    axi_read(32'h0, 4'd3, 12'h055, 0);
    check("rb_d0", rbuf[0], 32'd1);
    check("rb_d1", rbuf[1], 32'd2);
    check("rb_d2", rbuf[2], 32'd3);
    check("rb_d3", rbuf[3], 32'h4C454438);
    check("rb_l0", 32'(rlb[0]), 32'd0);
    check("rb_l1", 32'(rlb[1]), 32'd0);
    check("rb_l2", 32'(rlb[2]), 32'd0);
    check("rb_l3", 32'(rlb[3]), 32'd1);
    check("rb_resp3", 32'(rrb[3]), 32'd0);

    // blink: LED=0, BLINK=0F, PRESCALE=4 -> toggle every 5 cycles
    wbuf[0] = 32'h0;  axi_write(32'h0, 4'd0, 4'hF, 12'h1, 0);
    wbuf[0] = 32'h0F; axi_write(32'h4, 4'd0, 4'hF, 12'h2, 0);
    wbuf[0] = 32'h4;  axi_write(32'h8, 4'd0, 4'hF, 12'h3, 0);
    prev = led; n = 0;
    while (led == prev && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) check("blink_start", 32'd1, 32'd0);
    for (int k = 0; k < 3; k++) begin
      prev = led; n = 0;
      while (led == prev && n < 20) begin @(negedge clk); n++; end
      check("blink_period", 32'(n), 32'd5);
      check("blink_val", 32'(led), (prev == 8'h00) ? 32'h0F : 32'h00);
    end

    // byte strobes on PRESCALE, then an all-zero strobe
    wbuf[0] = 32'hFFFF_FFFF;
    axi_write(32'h8, 4'd0, 4'b0100, 12'h4, 0);
    axi_read(32'h8, 4'd0, 12'h4, 0);
    check("strb_lane2", rbuf[0], 32'h00FF_0004);
    axi_write(32'h8, 4'd0, 4'b0000, 12'h5, 0);
    axi_read(32'h8, 4'd0, 12'h5, 0);
    check("strb_none", rbuf[0], 32'h00FF_0004);
    axi_write(32'h0, 4'd0, 4'hF, 12'h6, 0);
    axi_read(32'h0, 4'd0, 12'h6, 0);
    check("led_unused_bits", rbuf[0], 32'h0000_00FF);

    // out-of-range address
    axi_read(32'h10, 4'd0, 12'h8, 0);
    check("oor_rresp", 32'(rrb[0]), 32'd2);
    check("oor_rdata", rbuf[0], 32'd0);
    wbuf[0] = 32'h0000_0011;
    axi_write(32'h10, 4'd0, 4'hF, 12'h9, 0);
    check("oor_bresp", 32'(wresp), 32'd2);
    axi_read(32'h0, 4'd0, 12'hA, 0);
    check("oor_nochg", rbuf[0], 32'h0000_00FF);

    // reset during beat 2 of a 4-beat read
    @(negedge clk);
    arvalid = 1'b1; araddr = 32'h0; arlen = 4'd3; arid = 12'hB;
    @(negedge clk);
    arvalid = 1'b0;
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    check("mid_rvalid_b2", 32'(rvalid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rvalid_drop", 32'(rvalid), 32'd0);
    check("mid_rst_led", 32'(led), 32'h55);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    axi_read(32'h0, 4'd1, 12'hC, 0);
    check("post_led",   rbuf[0], 32'h55);
    check("post_blink", rbuf[1], 32'h0);
    check("post_last",  32'(rlb[1]), 32'd1);
    axi_read(32'hC, 4'd0, 12'hD, 0);
    check("post_id",    rbuf[0], 32'h4C454438);
    check("post_rid",   32'(ridb), 32'hD);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
